wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbiter and sequencer for the single register-file write port fed by the write-back stage. Pipeline WB writes always take priority. Results from the multi-cycle multiply/divide unit (MDU) are buffered in a small FIFO and drained into idle WB slots. A starvation counter requests a pipeline bubble when buffered MDU results wait too long, and a hazard output blocks issue of instructions that touch a pending MDU destination.

## Interface
Parameters:
- DEPTH, 2, MDU result FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive blocked cycles before stall_req asserts (≥1)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset; 0 clears all state immediately
- wb_wreg  input  1  WB stage write enable
- wb_destR  input  5  WB destination register
- wb_dest  input  32  WB write data
- mdu_valid  input  1  MDU result valid
- mdu_ready  output  1  FIFO can accept; equals !full
- mdu_destR  input  5  MDU destination register
- mdu_data  input  32  MDU result
- id_rs, id_rt, id_rd  input  5 each  register numbers of the instruction in decode
- raw_hazard  output  1  decode register matches a pending MDU destination (combinational)
- stall_req  output  1  request one or more pipeline bubbles (registered)
- rf_we  output  1  register-file write enable (registered)
- rf_waddr  output  5  register-file write address (registered)
- rf_wdata  output  32  register-file write data (registered)
- fifo_cnt  output  clog2(DEPTH)+1  occupancy (registered)

## Operation
- WB slot is busy when wb_wreg=1 and wb_destR≠0. Otherwise it is free.
- WB busy: at the edge, rf_we=1, rf_waddr=wb_destR, rf_wdata=wb_dest. The FIFO does not pop.
- WB free and FIFO non-empty: pop the head, rf_we=1, rf_waddr/rf_wdata come from the head.
- WB free and FIFO empty: rf_we=0. rf_waddr and rf_wdata hold their previous values.
- A write to r0 is never issued. wb_wreg with wb_destR=0 is treated as a free slot. An MDU entry with destR=0 is accepted, popped and discarded with rf_we=0, and it consumes the slot.
- Push: when mdu_valid && mdu_ready, the entry is written at the tail.
  - Push and pop in the same cycle is allowed when not full. fifo_cnt is unchanged.
  - A pushed entry cannot pop in its push cycle. There is no bypass.
- mdu_ready = (fifo_cnt≠DEPTH). It is derived from registered count, so there is no combinational path from WB inputs.
- raw_hazard = 1 if any valid FIFO entry, or the incoming mdu_destR when mdu_valid=1, has a nonzero destR equal to id_rs, id_rt or id_rd.
  - Decode must not issue while raw_hazard=1. This guarantees no RAW/WAW conflicts between pipeline and MDU writes, so the arbiter performs no squashing.
- Starvation counter (3 states):
  - IDLE: FIFO empty, counter=0.
  - WAIT: FIFO non-empty and head blocked by a busy WB. The counter increments each blocked cycle.
  - STALL: entered when the counter reaches STARVE_MAX. stall_req=1.
  - Any pop returns to IDLE if the FIFO becomes empty, or to WAIT with counter=0 otherwise. stall_req clears at the edge of the pop.
- FIFO pointers wrap modulo DEPTH. Count saturates logically at DEPTH because push is blocked when full.

## Timing
- Reset (rst=0, asynchronous): rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0, fifo_cnt=0, pointers=0, counter=0, state IDLE. mdu_ready=1 during and after reset.
- Reset mid-operation discards all buffered entries. No write is issued for them.
- WB latency: wb_* sampled at edge N appear on rf_* after edge N (1 cycle).
- MDU latency: accepted at edge N, written to rf_* at edge N+1 at the earliest (2 cycles from mdu_valid).
- stall_req asserts after the edge on which the counter reaches STARVE_MAX. The pipeline bubble produces a free WB slot, and the head pops at that edge.
- raw_hazard is combinational within the cycle from FIFO state and mdu_*/id_* inputs.

## Test plan
- Reset: assert rst=0 mid-stream with 2 entries queued. Required: rf_we=0, fifo_cnt=0, mdu_ready=1 immediately; no queued write appears after release.
- WB priority: wb_wreg=1, wb_destR=5, wb_dest=0x11 while MDU pushes r7=0x22. Required: cycle+1 rf_* = (1,5,0x11); next idle WB cycle rf_* = (1,7,0x22).
- Full FIFO: DEPTH=2 with WB busy continuously and 3 MDU pushes. Required: mdu_ready=0 after 2 accepts; the third is held until a pop; order is preserved on drain.
- Starvation: STARVE_MAX=4, one entry queued, WB busy. Required: stall_req=1 after the 4th blocked edge; the WB bubble pops the entry; stall_req=0 at that same edge.
- Hazard: FIFO holds r9 and id_rt=9. Required: raw_hazard=1. With id_rt=0 against an r0 entry: raw_hazard=0.
- r0 suppression: wb_wreg=1, wb_destR=0. Required: rf_we=0, and a queued MDU entry drains in that slot.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline WB writes win, and buffered MDU results drain into
// idle WB slots. Also provides a starvation stall request and a decode RAW hazard flag.
module wb_port_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_wreg,
  input  logic [4:0]               wb_destR,
  input  logic [31:0]              wb_dest,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [4:0]               mdu_destR,
  input  logic [31:0]              mdu_data,
  input  logic [4:0]               id_rs,
  input  logic [4:0]               id_rt,
  input  logic [4:0]               id_rd,
  output logic                     raw_hazard,
  output logic                     stall_req,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {StIdle, StWait, StStall} starve_e;

  logic [4:0]    dest_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [CW-1:0] ctr_q, ctr_d;
  starve_e       state_q, state_d;
  logic          stall_q;
  logic          rf_we_q;
  logic [4:0]    rf_waddr_q;
  logic [31:0]   rf_wdata_q;

  logic          wb_busy, empty, full, push, pop;
  logic [4:0]    head_dest;
  logic [31:0]   head_data;

  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd);
    return (r != 5'd0) && ((r == rs) || (r == rt) || (r == rd));
  endfunction

  // A write to r0 never occupies the port, so the slot stays free for the FIFO.
  assign wb_busy   = wb_wreg && (wb_destR != 5'd0);
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign mdu_ready = !full;
  assign push      = mdu_valid && mdu_ready;
  assign pop       = !wb_busy && !empty;
  assign head_dest = dest_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    raw_hazard = mdu_valid && reg_match(mdu_destR, id_rs, id_rt, id_rd);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (((AW+1)'(i) < cnt_q) &&
          reg_match(dest_q[rd_ptr_q + AW'(i)], id_rs, id_rt, id_rd)) begin
        raw_hazard = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    if (pop) begin
      ctr_d   = '0;
      state_d = (cnt_d == '0) ? StIdle : StWait;
    end else if (!empty) begin
      // Non-empty without a pop means the head is blocked by a busy WB slot.
      if (state_q != StStall) begin
        ctr_d   = ctr_q + 1'b1;
        state_d = (ctr_d >= CW'(STARVE_MAX)) ? StStall : StWait;
      end
    end else begin
      ctr_d   = '0;
      state_d = push ? StWait : StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[wr_ptr_q] <= mdu_destR;
      data_q[wr_ptr_q] <= mdu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ctr_q      <= '0;
      state_q    <= StIdle;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      ctr_q   <= ctr_d;
      state_q <= state_d;
      stall_q <= (state_d == StStall);
      if (wb_busy) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= wb_destR;
        rf_wdata_q <= wb_dest;
      end else if (pop && (head_dest != 5'd0)) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= head_dest;
        rf_wdata_q <= head_data;
      end else begin
        // Idle slot or discarded r0 entry: address/data hold.
        rf_we_q <= 1'b0;
      end
    end
  end

  assign stall_req = stall_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign fifo_cnt  = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected register-file writes are queued as stimulus is
// driven and retired in order by a monitor; state outputs are checked at each step.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_wreg;
  logic [4:0]  wb_destR;
  logic [31:0] wb_dest;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_destR;
  logic [31:0] mdu_data;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        raw_hazard;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  fifo_cnt;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_wreg    (wb_wreg),
    .wb_destR   (wb_destR),
    .wb_dest    (wb_dest),
    .mdu_valid  (mdu_valid),
    .mdu_ready  (mdu_ready),
    .mdu_destR  (mdu_destR),
    .mdu_data   (mdu_data),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .raw_hazard (raw_hazard),
    .stall_req  (stall_req),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .fifo_cnt   (fifo_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] r, input logic [31:0] d);
    wb_wreg  = we;
    wb_destR = r;
    wb_dest  = d;
  endtask

  task automatic set_mdu(input logic v, input logic [4:0] r, input logic [31:0] d);
    mdu_valid = v;
    mdu_destR = r;
    mdu_data  = d;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    sb.push_back(w);
  endtask

  // Every issued write must be the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_write observed=%0h:%0h expected=none", rf_waddr, rf_wdata);
      end
      if (sb.size() > 0) begin
        wr_t w;
        w = sb.pop_front();
        chk("sb_waddr", 32'(rf_waddr), 32'(w.addr));
        chk("sb_wdata", rf_wdata, w.data);
      end
    end
  end

  initial begin
    rst = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0);
    set_mdu(1'b0, 5'd0, 32'd0);
    id_rs = 5'd0;
    id_rt = 5'd0;
    id_rd = 5'd0;
    #1;
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_cnt", 32'(fifo_cnt), 32'd0);
    chk("rst_ready", 32'(mdu_ready), 32'd1);
    chk("rst_stall", 32'(stall_req), 32'd0);
    repeat (2) cyc();
    rst = 1'b1;

    // WB priority over a simultaneous MDU push.
    set_wb(1'b1, 5'd5, 32'h11);
    set_mdu(1'b1, 5'd7, 32'h22);
    expect_wr(5'd5, 32'h11);
    cyc();
    chk("prio_we", 32'(rf_we), 32'd1);
    chk("prio_waddr", 32'(rf_waddr), 32'd5);
    chk("prio_cnt", 32'(fifo_cnt), 32'd1);
    set_wb(1'b0, 5'd0, 32'd0);
    set_mdu(1'b0, 5'd0, 32'd0);
    id_rt = 5'd7;
    #1;
    chk("hz_r7", 32'(raw_hazard), 32'd1);
    id_rt = 5'd0;
    expect_wr(5'd7, 32'h22);
    cyc();
    chk("drain_waddr", 32'(rf_waddr), 32'd7);
    chk("drain_cnt", 32'(fifo_cnt), 32'd0);

    // Full FIFO with WB busy: third push is held until a pop; drain order preserved.
    set_wb(1'b1, 5'd1, 32'hA1);
    set_mdu(1'b1, 5'd10, 32'h100);
    expect_wr(5'd1, 32'hA1);
    cyc();
    chk("full_cnt1", 32'(fifo_cnt), 32'd1);
    chk("full_rdy1", 32'(mdu_ready), 32'd1);
    set_wb(1'b1, 5'd2, 32'hA2);
    set_mdu(1'b1, 5'd11, 32'h101);
    expect_wr(5'd2, 32'hA2);
    cyc();
    chk("full_cnt2", 32'(fifo_cnt), 32'd2);
    chk("full_rdy2", 32'(mdu_ready), 32'd0);
    set_wb(1'b1, 5'd3, 32'hA3);
    set_mdu(1'b1, 5'd12, 32'h102);
    id_rs = 5'd12;
    #1;
    chk("hz_incoming", 32'(raw_hazard), 32'd1);
    id_rs = 5'd0;
    expect_wr(5'd3, 32'hA3);
    cyc();
    chk("full_held_cnt", 32'(fifo_cnt), 32'd2);
    chk("full_no_stall", 32'(stall_req), 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    expect_wr(5'd10, 32'h100);
    cyc();
    chk("full_pop_cnt", 32'(fifo_cnt), 32'd1);
    chk("full_pop_rdy", 32'(mdu_ready), 32'd1);
    expect_wr(5'd11, 32'h101);
    cyc();
    chk("full_pp_cnt", 32'(fifo_cnt), 32'd1);
    set_mdu(1'b0, 5'd0, 32'd0);
    expect_wr(5'd12, 32'h102);
    cyc();
    chk("full_empty", 32'(fifo_cnt), 32'd0);

    // Starvation: one entry blocked for STARVE_MAX edges, then a bubble drains it.
    set_wb(1'b1, 5'd20, 32'hB0);
    set_mdu(1'b1, 5'd9, 32'h99);
    expect_wr(5'd20, 32'hB0);
    cyc();
    set_mdu(1'b0, 5'd0, 32'd0);
    id_rt = 5'd9;
    #1;
    chk("hz_r9", 32'(raw_hazard), 32'd1);
    id_rt = 5'd0;
    for (int k = 1; k <= 4; k++) begin
      set_wb(1'b1, 5'(20 + k), 32'hB0 + 32'(k));
      expect_wr(5'(20 + k), 32'hB0 + 32'(k));
      cyc();
      chk($sformatf("starve_%0d", k), 32'(stall_req), (k >= 4) ? 32'd1 : 32'd0);
    end
    set_wb(1'b0, 5'd0, 32'd0);
    expect_wr(5'd9, 32'h99);
    cyc();
    chk("starve_clear", 32'(stall_req), 32'd0);
    chk("starve_cnt", 32'(fifo_cnt), 32'd0);

    // r0 handling: r0 entry raises no hazard and is discarded; wb to r0 frees the slot.
    set_wb(1'b1, 5'd6, 32'h66);
    set_mdu(1'b1, 5'd0, 32'h55);
    expect_wr(5'd6, 32'h66);
    cyc();
    set_mdu(1'b0, 5'd0, 32'd0);
    #1;
    chk("hz_r0", 32'(raw_hazard), 32'd0);
    set_wb(1'b1, 5'd0, 32'h77);
    cyc();
    chk("r0_disc_we", 32'(rf_we), 32'd0);
    chk("r0_disc_cnt", 32'(fifo_cnt), 32'd0);
    set_mdu(1'b1, 5'd14, 32'hEE);
    cyc();
    chk("r0_push_we", 32'(rf_we), 32'd0);
    chk("r0_push_cnt", 32'(fifo_cnt), 32'd1);
    set_mdu(1'b0, 5'd0, 32'd0);
    expect_wr(5'd14, 32'hEE);
    cyc();
    chk("r0_slot_we", 32'(rf_we), 32'd1);
    chk("r0_slot_waddr", 32'(rf_waddr), 32'd14);
    set_wb(1'b0, 5'd0, 32'd0);

    // Reset mid-stream with two entries queued: they must never be written.
    set_wb(1'b1, 5'd3, 32'h33);
    set_mdu(1'b1, 5'd4, 32'h44);
    expect_wr(5'd3, 32'h33);
    cyc();
    set_wb(1'b1, 5'd3, 32'h34);
    set_mdu(1'b1, 5'd5, 32'h45);
    expect_wr(5'd3, 32'h34);
    cyc();
    chk("mid_cnt", 32'(fifo_cnt), 32'd2);
    @(negedge clk);
    #1;
    rst = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0);
    set_mdu(1'b0, 5'd0, 32'd0);
    #1;
    chk("mid_rst_we", 32'(rf_we), 32'd0);
    chk("mid_rst_cnt", 32'(fifo_cnt), 32'd0);
    chk("mid_rst_ready", 32'(mdu_ready), 32'd1);
    repeat (2) cyc();
    rst = 1'b1;
    repeat (4) cyc();
    chk("post_rst_cnt", 32'(fifo_cnt), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
